// File: rtl/async_queue_sink_param.sv
`default_nettype none
// ============================================================================
//  Module   : async_queue_sink_param
//  Purpose  : Dequeue (sink) half of a clock-crossing queue holding
//             2**DEPTH_LOG2 entries of WIDTH bits. Payload is read directly
//             from the source-owned storage array; the source write pointer
//             (gray) and liveness flag are synchronised into this domain, and
//             the sink read pointer (gray) and liveness flag are returned.
//             Also provides a registered fill level and an almost-empty flag.
//  Ports    : clock, reset_n      sink clock, async active-low reset
//             mem_i               source storage, entry k at [k*WIDTH +: WIDTH]
//             widx_gray_i         source write pointer (gray, asynchronous)
//             src_alive_i         source liveness (asynchronous)
//             ridx_gray_o         sink read pointer (gray, registered)
//             sink_alive_o        sink liveness (registered)
//             deq_valid_o/ready_i dequeue handshake
//             deq_bits_o          payload (registered)
//             fill_level_o        entries held (registered)
//             almost_empty_o      fill_level_o <= AE_LEVEL (registered)
//  Revision : 1.0  initial release
// ============================================================================
module async_queue_sink_param #(
  parameter int DEPTH_LOG2  = 3,
  parameter int WIDTH       = 43,
  parameter int SYNC_STAGES = 3,
  parameter int AE_LEVEL    = 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [WIDTH*(2**DEPTH_LOG2)-1:0] mem_i,
  input  logic [DEPTH_LOG2:0]             widx_gray_i,
  input  logic                            src_alive_i,
  output logic [DEPTH_LOG2:0]             ridx_gray_o,
  output logic                            sink_alive_o,
  output logic                            deq_valid_o,
  input  logic                            deq_ready_i,
  output logic [WIDTH-1:0]                deq_bits_o,
  output logic [DEPTH_LOG2:0]             fill_level_o,
  output logic                            almost_empty_o
);

  localparam int         PTR_W   = DEPTH_LOG2 + 1;
  localparam int         ENTRIES = 2 ** DEPTH_LOG2;
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_LEVEL);

  // Storage viewed as an array so the read mux indexes by entry.
  logic [WIDTH-1:0] mem_w [ENTRIES];

  generate
    for (genvar k = 0; k < ENTRIES; k++) begin : g_unpack
      assign mem_w[k] = mem_i[k*WIDTH +: WIDTH];
    end
  endgenerate

  // Inbound synchronisers: plain flop chains, one per bit.
  logic [PTR_W-1:0]       widx_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] alive_sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) widx_sync_q[i] <= '0;
      alive_sync_q <= '0;
    end else begin
      widx_sync_q[0] <= widx_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) widx_sync_q[i] <= widx_sync_q[i-1];
      alive_sync_q <= {alive_sync_q[SYNC_STAGES-2:0], src_alive_i};
    end
  end

  logic [PTR_W-1:0] widx_sync;
  logic             alive_sync;
  assign widx_sync  = widx_sync_q[SYNC_STAGES-1];
  assign alive_sync = alive_sync_q[SYNC_STAGES-1];

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Sink state
  logic [PTR_W-1:0] ridx_bin_q, ridx_gray_q, fill_q;
  logic             valid_q, ae_q, sink_alive_q;
  logic [WIDTH-1:0] bits_q;

  // Next-state
  logic             fire;
  logic [PTR_W-1:0] ridx_d, ridx_gray_d, fill_d;
  logic             valid_d, ae_d;

  // Valid is masked by the synchronised liveness so the consumer sees the
  // drop in the very cycle the source is known to be gone.
  assign deq_valid_o = valid_q & alive_sync;
  assign fire        = deq_valid_o & deq_ready_i;

  always_comb begin
    ridx_d      = alive_sync ? (ridx_bin_q + {{(PTR_W-1){1'b0}}, fire}) : '0;
    ridx_gray_d = ridx_d ^ (ridx_d >> 1);
    // Empty test is done in gray space against the synchronised pointer.
    valid_d     = alive_sync & (ridx_gray_d != widx_sync);
    fill_d      = alive_sync ? (gray2bin(widx_sync) - ridx_d) : '0;
    ae_d        = (fill_d <= AE_LVL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ridx_bin_q   <= '0;
      ridx_gray_q  <= '0;
      valid_q      <= 1'b0;
      bits_q       <= '0;
      fill_q       <= '0;
      ae_q         <= 1'b1;
      sink_alive_q <= 1'b0;
    end else begin
      ridx_bin_q   <= ridx_d;
      ridx_gray_q  <= ridx_gray_d;
      valid_q      <= valid_d;
      fill_q       <= fill_d;
      ae_q         <= ae_d;
      sink_alive_q <= 1'b1;
      // Load only when a valid entry is next; otherwise hold so the payload
      // stays stable under backpressure.
      if (valid_d) bits_q <= mem_w[ridx_d[DEPTH_LOG2-1:0]];
    end
  end

  assign ridx_gray_o    = ridx_gray_q;
  assign sink_alive_o   = sink_alive_q;
  assign deq_bits_o     = bits_q;
  assign fill_level_o   = fill_q;
  assign almost_empty_o = ae_q;

endmodule
`default_nettype wire

// File: tb/tb_async_queue_sink_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_async_queue_sink_param
//  Purpose  : Self-checking bench for async_queue_sink_param (default params).
//             A small source model writes storage and publishes gray write
//             pointers; a queue holds the expected payload order.
//  Revision : 1.0  initial release
// ============================================================================
module tb_async_queue_sink_param;

  localparam int DL = 3;
  localparam int W  = 43;
  localparam int SS = 3;
  localparam int N  = 2 ** DL;
  localparam int PW = DL + 1;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [W*N-1:0]  mem = '0;
  logic [PW-1:0]   widx_gray = '0;
  logic            src_alive = 1'b0;
  logic [PW-1:0]   ridx_gray;
  logic            sink_alive;
  logic            deq_valid;
  logic            deq_ready = 1'b0;
  logic [W-1:0]    deq_bits;
  logic [PW-1:0]   fill_level;
  logic            almost_empty;

  async_queue_sink_param #(
    .DEPTH_LOG2(DL), .WIDTH(W), .SYNC_STAGES(SS), .AE_LEVEL(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .mem_i(mem), .widx_gray_i(widx_gray),
    .src_alive_i(src_alive), .ridx_gray_o(ridx_gray), .sink_alive_o(sink_alive),
    .deq_valid_o(deq_valid), .deq_ready_i(deq_ready), .deq_bits_o(deq_bits),
    .fill_level_o(fill_level), .almost_empty_o(almost_empty)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0]  expq[$];
  logic [PW-1:0] wbin = '0;
  int            seq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Source model: write the slot, then publish the advanced pointer.
  task automatic push(input logic [W-1:0] d);
    mem[int'(wbin[DL-1:0])*W +: W] = d;
    wbin      = wbin + 1'b1;
    widx_gray = bin2gray(wbin);
    expq.push_back(d);
  endtask

  function automatic logic [W-1:0] next_data();
    seq++;
    return {11'(seq * 3 + 1), 32'hA5C3_0000 ^ 32'(seq * 32'h0001_0101)};
  endfunction

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      push(next_data());
      tick();
    end
  endtask

  task automatic settle();
    for (int i = 0; i < SS + 2; i++) tick();
  endtask

  task automatic pop_n(input int n, input string name);
    deq_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({name, "_valid"}, 64'(deq_valid), 64'd1);
      if (expq.size() == 0) begin
        chk({name, "_model_empty"}, 64'd1, 64'd0);
      end else begin
        chk({name, "_bits"}, 64'(deq_bits), 64'(expq[0]));
        void'(expq.pop_front());
      end
      tick();
    end
    deq_ready = 1'b0;
  endtask

  typedef struct {
    int            n_push;
    logic [PW-1:0] fill;
    logic          ae;
    int            n_pop;
    logic [PW-1:0] gray;   // read pointer after the pops
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Global safety net.
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;
    int          cyc, pushed, occ;
    logic        done;

    tbl[0] = '{7, 4'd7, 1'b0, 7, 4'b1100};
    tbl[1] = '{8, 4'd8, 1'b0, 8, 4'b0000};
    tbl[2] = '{1, 4'd1, 1'b1, 0, 4'b0000};
    tbl[3] = '{0, 4'd1, 1'b1, 1, 4'b0001};
    tbl[4] = '{6, 4'd6, 1'b0, 5, 4'b0101};
    tbl[5] = '{3, 4'd4, 1'b0, 4, 4'b1111};
    tbl[6] = '{2, 4'd2, 1'b0, 1, 4'b1110};
    tbl[7] = '{0, 4'd1, 1'b1, 1, 4'b1010};
    tbl[8] = '{0, 4'd0, 1'b1, 0, 4'b1010};

    // ---------------- reset ----------------
    for (int i = 0; i < 3; i++) tick();
    chk("rst_valid",   64'(deq_valid),    64'd0);
    chk("rst_ridx",    64'(ridx_gray),    64'd0);
    chk("rst_fill",    64'(fill_level),   64'd0);
    chk("rst_ae",      64'(almost_empty), 64'd1);
    chk("rst_alive",   64'(sink_alive),   64'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_alive_before_edge", 64'(sink_alive), 64'd0);
    tick();
    chk("rel_alive_after_edge",  64'(sink_alive), 64'd1);

    // ---------------- single entry, exact latency ----------------
    src_alive = 1'b1;
    for (int i = 0; i < SS + 1; i++) tick();
    push(43'h123);
    for (int i = 0; i < SS; i++) tick();
    chk("single_valid_early", 64'(deq_valid), 64'd0);
    tick();
    chk("single_valid",  64'(deq_valid), 64'd1);
    chk("single_bits",   64'(deq_bits),  64'h123);
    chk("single_fill",   64'(fill_level), 64'd1);
    deq_ready = 1'b1;
    void'(expq.pop_front());
    tick();
    deq_ready = 1'b0;
    chk("single_ridx",   64'(ridx_gray), 64'b0001);
    chk("single_valid0", 64'(deq_valid), 64'd0);

    // ---------------- table: fill / drain / wrap ----------------
    foreach (tbl[r]) begin
      push_n(tbl[r].n_push);
      settle();
      chk($sformatf("tbl%0d_fill", r), 64'(fill_level),   64'(tbl[r].fill));
      chk($sformatf("tbl%0d_ae", r),   64'(almost_empty), 64'(tbl[r].ae));
      chk($sformatf("tbl%0d_valid", r), 64'(deq_valid),   64'(tbl[r].fill != 0));
      pop_n(tbl[r].n_pop, $sformatf("tbl%0d_pop", r));
      chk($sformatf("tbl%0d_ridx", r), 64'(ridx_gray),    64'(tbl[r].gray));
    end

    // ---------------- backpressure with concurrent pushes ----------------
    pat    = 32'b1011_0010_1110_0101_1001_1100_0110_1011;
    cyc    = 0;
    pushed = 0;
    done   = 1'b0;
    while (!done && cyc < 500) begin
      deq_ready = pat[cyc % 32];
      occ = expq.size();
      if (deq_valid) begin
        if (expq.size() == 0) chk("bp_unexpected_valid", 64'd1, 64'd0);
        else chk("bp_bits", 64'(deq_bits), 64'(expq[0]));
        if (deq_ready && expq.size() != 0) void'(expq.pop_front());
      end
      if (pushed < 19 && occ < N) begin
        push(next_data());
        pushed++;
      end
      tick();
      cyc++;
      if (pushed == 19 && expq.size() == 0) done = 1'b1;
    end
    deq_ready = 1'b0;
    if (!done) chk("bp_timeout", 64'd1, 64'd0);
    settle();
    chk("bp_ridx",  64'(ridx_gray),  64'b1000);
    chk("bp_fill",  64'(fill_level), 64'd0);
    chk("bp_valid", 64'(deq_valid),  64'd0);

    // ---------------- source death ----------------
    push_n(3);
    settle();
    chk("death_fill_pre",  64'(fill_level), 64'd3);
    chk("death_valid_pre", 64'(deq_valid),  64'd1);
    src_alive = 1'b0;
    wbin      = '0;
    widx_gray = '0;
    tick();
    tick();
    chk("death_valid_still", 64'(deq_valid), 64'd1);
    tick();
    chk("death_valid_drop", 64'(deq_valid), 64'd0);
    chk("death_ridx_hold",  64'(ridx_gray), 64'b1000);
    tick();
    chk("death_ridx",  64'(ridx_gray),    64'd0);
    chk("death_fill",  64'(fill_level),   64'd0);
    chk("death_ae",    64'(almost_empty), 64'd1);
    chk("death_valid", 64'(deq_valid),    64'd0);
    expq.delete();

    src_alive = 1'b1;
    for (int i = 0; i < SS + 1; i++) tick();
    push_n(2);
    settle();
    chk("revive_fill", 64'(fill_level), 64'd2);
    pop_n(2, "revive_pop");
    chk("revive_ridx", 64'(ridx_gray), 64'b0011);

    // ---------------- async reset mid-drain ----------------
    push_n(2);
    settle();
    chk("ar_valid_pre", 64'(deq_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(deq_valid),    64'd0);
    chk("ar_ridx",  64'(ridx_gray),    64'd0);
    chk("ar_fill",  64'(fill_level),   64'd0);
    chk("ar_ae",    64'(almost_empty), 64'd1);
    chk("ar_alive", 64'(sink_alive),   64'd0);
    chk("ar_bits",  64'(deq_bits),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
